pipe_stage_buffer: RTL
======================

Name: pipe_stage_buffer

Overview:
Parametrised inter-stage pipeline buffer for the 5-stage datapath. It is the generalised successor to the fixed stage registers and can be instantiated for IF/ID, ID/EXE, EXE/MEM or MEM/WB. It carries instruction, control word and N data words, with a valid/ready handshake and a 2-entry skid so back-pressure never drops data. It also supports a global stall (go), a flush (clear) and a saturating count of flushed entries.

Parameters:
INSTR_W, 32, instruction field width
CTRL_W, 15, control-message width
DATA_W, 32, width of each data word
NUM_DATA, 3, number of data words carried (e.g. alu, A, B)
CNT_W, 8, width of flush counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
go  in  1  stage enable; 0 = full stall, nothing moves
clear  in  1  synchronous flush of all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  buffer can accept this cycle
in_instruction  in  INSTR_W  instruction in
in_ctrl  in  CTRL_W  control message in
in_data  in  NUM_DATA*DATA_W  packed data words, word k at [k*DATA_W +: DATA_W]
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_instruction  out  INSTR_W  instruction out
out_ctrl  out  CTRL_W  control out
out_data  out  NUM_DATA*DATA_W  packed data out
flush_cnt  out  CNT_W  saturating count of valid entries discarded by clear

Behaviour:
- Storage: main entry (drives out_*) plus skid entry. Each entry has a valid bit.
- Occupancy states: EMPTY (none valid), ONE (main only), FULL (main+skid). Skid is never valid without main.
- in_ready = go & ~clear & ~skid_valid (combinational from registered state and inputs).
- out_valid = go & ~clear & main_valid. out_* payload always reflects the main register.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Transitions, when go=1, clear=0, rst=0:
  - EMPTY: push -> ONE, main <= in.
  - ONE: push & pop -> ONE, main <= in. push only -> FULL, skid <= in. pop only -> EMPTY.
  - FULL: push impossible. pop -> ONE, main <= skid. No pop -> hold.
- Latency: 1 cycle from push into EMPTY to out_valid. Sustained throughput is 1 transfer/cycle with out_ready held high.
- go=0: no push, no pop, all registers hold, flush_cnt holds.
- clear=1 (priority over go and handshake):
  - Next cycle both valid bits are 0 and all payload registers are 0.
  - In-cycle input is dropped. No handshake completes because in_ready=0 and out_valid=0.
  - flush_cnt += (main_valid + skid_valid), saturating at 2^CNT_W-1 and never wrapping.
- rst=1 (priority over clear): valids 0, payloads 0, flush_cnt 0.
  - Resulting outputs: in_ready=go&~clear, out_valid=0, out_* = 0.
  - Reset mid-transfer discards held entries without counting them.
- Payload of an entry that becomes invalid via pop retains its last value. Downstream must qualify it with out_valid.
- Payload width rules: fields are passed through bit-exact with no truncation or extension.

Test Plan:
- Reset/pass-through: rst 1 cycle, then push instr=0x8C220004, ctrl=0x1A5, data={3,2,1} with out_ready=1 -> out_valid=1 on the next cycle with identical fields, in_ready stays 1, flush_cnt=0.
- Back-pressure: out_ready=0, push A then B -> FULL, in_ready=0. A third push of C is not accepted. Raise out_ready -> out order is A, B, then C after it is re-presented. No loss, no duplication.
- Stall: FULL, go=0 for 5 cycles with in_valid=out_ready=1 -> in_ready=0, out_valid=0, state and payload unchanged. go=1 -> transfers resume in order.
- Flush: FULL, assert clear while in_valid=1 -> next cycle EMPTY, out_* = 0, flush_cnt=2. Input from the clear cycle is not captured.
- Flush saturation: CNT_W=2, perform 3 flushes of FULL -> flush_cnt = 2, then 3, then 3.
- Priority: rst and clear both high while ONE -> EMPTY, flush_cnt=0. Streaming 100 random beats with random out_ready/go -> output sequence equals input sequence (scoreboard).

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: inter-stage pipeline register with valid/ready, 2-entry skid, stall, flush and flush counter
module pipe_stage_buffer #(
    parameter int INSTR_W  = 32,
    parameter int CTRL_W   = 15,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instruction,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instruction,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]           flush_cnt
);
    localparam int PW = INSTR_W + CTRL_W + NUM_DATA * DATA_W;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nx;
    logic [PW-1:0] main_q, skid_q, in_p;
    logic main_valid, skid_valid, push, pop;
    logic [CNT_W:0] cnt_sum;
    assign main_valid = state != EMPTY;
    assign skid_valid = state == FULL;
    assign in_ready = go & ~clear & ~skid_valid;
    assign out_valid = go & ~clear & main_valid;
    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    assign in_p = {in_instruction, in_ctrl, in_data};
    assign {out_instruction, out_ctrl, out_data} = main_q;
    // one extra bit catches overflow so the count saturates instead of wrapping
    assign cnt_sum = {1'b0, flush_cnt} + (CNT_W+1)'(main_valid) + (CNT_W+1)'(skid_valid);
    always_comb begin
        state_nx = clear ? EMPTY :
                   state == EMPTY ? (push ? ONE : EMPTY) :
                   state == ONE ? ((push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE) :
                   (pop ? ONE : FULL);
    end
    always_ff @(posedge clk) begin
        state <= rst ? EMPTY : state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (push && (!main_valid || pop))
                main_q <= in_p;
            else if (pop && skid_valid)
                main_q <= skid_q;
            if (push && main_valid && !pop)
                skid_q <= in_p;
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt <= '0;
        else if (clear)
            flush_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
endmodule
